dbg_trig_seq: RTL
=================

# dbg_trig_seq

Trigger sequencer for the on-chip debug capture path. Selects one of NSRC debug buses and registers it toward the ILA probe. Arms on command, waits for a masked-compare trigger, then gates a capture-enable for exactly `post_len+1` samples. Sits between the flash-controller debug taps and the ILA wrapper, so ILA storage is spent only on the window of interest.

## Interface
- NSRC, 4, number of debug source buses (≥2)
- DW, 64, width of each source bus and of the probe
- POST_W, 16, width of the post-trigger length and sample counter
- v_clk0  in  1  capture clock
- v_rst0  in  1  reset; synchronous, active-high; one clock; all state in v_clk0 domain
- v_src_data  in  NSRC*DW  concatenated sources; source i at [i*DW +: DW]
- v_sel  in  $clog2(NSRC)  source select, latched at arm
- v_arm  in  1  arm request (level sampled per cycle)
- v_abort  in  1  abort capture, highest priority
- v_trig_mask  in  DW  compare mask, latched at arm
- v_trig_value  in  DW  compare value, latched at arm
- v_post_len  in  POST_W  samples after trigger sample, latched at arm
- v_probe_data  out  DW  registered selected source, to ILA probe
- v_probe_en  out  1  capture qualifier aligned with v_probe_data
- v_trig_out  out  1  one-cycle pulse aligned with trigger sample on v_probe_data
- v_state  out  2  IDLE=0, ARMED=1, CAPTURE=2, DONE=3
- v_done  out  1  high while in DONE
- v_sample_cnt  out  POST_W  samples captured since last arm

## Operation
- Stage 1: s1 <= src[sel_q] every cycle, regardless of state. sel_q, mask_q, value_q, len_q are loaded when an arm is accepted.
- match = ((s1 ^ value_q) & mask_q) == 0. mask_q = 0 matches every sample.
- IDLE: v_arm=1 → accept arm, latch config, clear v_sample_cnt → ARMED.
- ARMED: trigger condition true on s1 → CAPTURE. Stage 2 outputs the trigger sample with v_probe_en=1 and v_trig_out=1. Counter = 0 at that point.
- CAPTURE: each cycle v_probe_en=1 and v_sample_cnt increments. After len_q further samples → DONE. Total enables = len_q+1. len_q=0 → DONE directly after the trigger sample.
- DONE: v_done=1, v_probe_en=0. v_arm=1 → re-arm (same as IDLE acceptance).
- v_arm in ARMED or CAPTURE is ignored. v_arm is level-sensitive and re-arms on every cycle it is high in IDLE/DONE.
- v_abort=1 in any state → IDLE next cycle. Abort wins over a simultaneous arm or trigger. v_probe_en and v_trig_out are 0 from the next cycle. v_sample_cnt holds its value.
- v_sample_cnt saturates at all-ones. It cannot exceed len_q+1 ≤ 2^POST_W. The len_q = all-ones case saturates without wrap.
- Changes on v_sel/mask/value/post_len while not accepting an arm have no effect.

## Timing
- Reset values: v_probe_data=0, v_probe_en=0, v_trig_out=0, v_state=IDLE, v_done=0, v_sample_cnt=0. s1, stage 2 and latched config are all cleared.
- Reset mid-capture behaves as abort plus config clear. Reset has priority over abort.
- Source to v_probe_data latency: 2 cycles.
- Arm accepted in cycle t → ARMED visible at t+1.
- The first sample eligible for compare is src[sel_q] presented at t+1, which lands in s1 at t+2.
- Trigger sample in s1 at cycle k → v_probe_data holds it at k+1 with v_probe_en=1, v_trig_out=1, v_state=CAPTURE.
- Last enabled sample at k+1+len_q. v_state=DONE at k+2+len_q.
- Throughput: one sample per clock, no backpressure.

## Configuration
- DBG_TRIG_OCC_EN defined:
  - Adds input v_trig_occ [7:0], latched at arm.
  - The trigger condition is the v_trig_occ-th match in ARMED. Value 0 is treated as 1.
  - An 8-bit occurrence counter clears at arm and saturates at 255.
- DBG_TRIG_OCC_EN undefined:
  - Port absent; the first match triggers.

## Structure
- Package dbg_trig_pkg holds:
  - state enum (IDLE/ARMED/CAPTURE/DONE) and its 2-bit encoding
  - default DW/NSRC/POST_W constants
  - occurrence counter width (8)
- Sub-module dbg_trig_match holds:
  - masked comparator
  - occurrence counter under DBG_TRIG_OCC_EN
  - outputs a single-cycle trig_hit
- The top level holds the source mux, FSM, counters and output registers.

## Test plan
- Arm with sel=2, mask=0xFF, value=0x5A, post_len=3; drive src2 low byte 0x5A once at cycle 10 → v_trig_out at 12, v_probe_en high 12..15, v_done from 16, v_sample_cnt=3.
- post_len=0, mask=0 → trigger on first post-arm sample; exactly one v_probe_en cycle; DONE the cycle after.
- Assert v_abort during CAPTURE after 2 samples with post_len=10 → IDLE next cycle, v_probe_en=0, v_sample_cnt=2; v_arm in same cycle as abort ignored.
- Change v_sel and v_trig_value while ARMED → compare still uses latched config; trigger only on the original source/value.
- Assert v_rst0 mid-CAPTURE → all outputs at reset values next cycle; re-arm afterwards works normally.
- With DBG_TRIG_OCC_EN, v_trig_occ=3, value matched at cycles 5, 8, 11 → trigger on the cycle-11 sample only; v_trig_occ=0 triggers on cycle 5.

Source files
------------

// File: rtl/dbg_trig_pkg.sv
// dbg_trig_pkg: shared states and default sizing for the debug trigger sequencer
package dbg_trig_pkg;
  localparam int NSRC_DEF = 4;
  localparam int DW_DEF = 64;
  localparam int POST_W_DEF = 16;
  localparam int OCC_W = 8;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;
endpackage

// File: rtl/dbg_trig_match.sv
// dbg_trig_match: masked compare of the stage-1 sample, producing a one-cycle hit
// DBG_TRIG_OCC_EN adds an n-th occurrence qualifier with its own counter
module dbg_trig_match
  import dbg_trig_pkg::*;
#(
  parameter int DW = DW_DEF
) (
`ifdef DBG_TRIG_OCC_EN
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic [OCC_W-1:0] occ_i,
`endif
  input  logic [DW-1:0]    s1_i,
  input  logic [DW-1:0]    mask_i,
  input  logic [DW-1:0]    value_i,
  input  logic             armed_i,
  output logic             hit_o
);
  logic match;
  assign match = ((s1_i ^ value_i) & mask_i) == '0;
`ifdef DBG_TRIG_OCC_EN
  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] cnt_q;
  logic [OCC_W:0]   tgt;
  // a requested occurrence of zero behaves as the first match
  assign tgt = (occ_q == '0) ? (OCC_W+1)'(1) : {1'b0, occ_q};
  assign hit_o = armed_i && match && (({1'b0, cnt_q} + (OCC_W+1)'(1)) >= tgt);
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q <= '0;
      cnt_q <= '0;
    end else if (clr_i) begin
      occ_q <= occ_i;
      cnt_q <= '0;
    end else if (armed_i && match && cnt_q != '1) begin
      cnt_q <= cnt_q + OCC_W'(1);
    end
  end
`else
  assign hit_o = armed_i && match;
`endif
endmodule

// File: rtl/dbg_trig_seq.sv
// dbg_trig_seq: source select, arm/trigger/capture sequencing and probe registers
// DBG_TRIG_OCC_EN adds v_trig_occ to trigger on the n-th match
module dbg_trig_seq
  import dbg_trig_pkg::*;
#(
  parameter int NSRC   = NSRC_DEF,
  parameter int DW     = DW_DEF,
  parameter int POST_W = POST_W_DEF
) (
  input  logic                    v_clk0,
  input  logic                    v_rst0,
  input  logic [NSRC*DW-1:0]      v_src_data,
  input  logic [$clog2(NSRC)-1:0] v_sel,
  input  logic                    v_arm,
  input  logic                    v_abort,
  input  logic [DW-1:0]           v_trig_mask,
  input  logic [DW-1:0]           v_trig_value,
  input  logic [POST_W-1:0]       v_post_len,
`ifdef DBG_TRIG_OCC_EN
  input  logic [OCC_W-1:0]        v_trig_occ,
`endif
  output logic [DW-1:0]           v_probe_data,
  output logic                    v_probe_en,
  output logic                    v_trig_out,
  output logic [1:0]              v_state,
  output logic                    v_done,
  output logic [POST_W-1:0]       v_sample_cnt
);
  localparam int SW = $clog2(NSRC);
  state_e            state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [DW-1:0]     mask_q, mask_d;
  logic [DW-1:0]     value_q, value_d;
  logic [POST_W-1:0] len_q, len_d;
  logic [POST_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]     s1_q, pd_q;
  logic              trig_q, trig_d;
  logic              elig_q, elig_d;
  logic              arm_ok, hit;
  logic [DW-1:0]     src [NSRC];
  for (genvar i = 0; i < NSRC; i++) begin : g_src
    assign src[i] = v_src_data[i*DW +: DW];
  end
  assign arm_ok = v_arm && !v_abort && (state_q == IDLE || state_q == DONE);
  dbg_trig_match #(.DW(DW)) u_match (
`ifdef DBG_TRIG_OCC_EN
    .clk     (v_clk0),
    .rst     (v_rst0),
    .clr_i   (arm_ok),
    .occ_i   (v_trig_occ),
`endif
    .s1_i    (s1_q),
    .mask_i  (mask_q),
    .value_i (value_q),
    .armed_i (state_q == ARMED && elig_q),
    .hit_o   (hit)
  );
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    mask_d  = mask_q;
    value_d = value_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    trig_d  = 1'b0;
    // s1 holds a sample of the latched source only once ARMED has lasted a full cycle
    elig_d  = state_q == ARMED && !v_abort;
    if (v_abort) begin
      state_d = IDLE;
    end else if (arm_ok) begin
      state_d = ARMED;
      sel_d   = v_sel;
      mask_d  = v_trig_mask;
      value_d = v_trig_value;
      len_d   = v_post_len;
      cnt_d   = '0;
    end else if (state_q == ARMED && hit) begin
      state_d = CAPTURE;
      trig_d  = 1'b1;
    end else if (state_q == CAPTURE) begin
      state_d = (cnt_q == len_q) ? DONE : CAPTURE;
      cnt_d   = (cnt_q == len_q) ? cnt_q : cnt_q + POST_W'(cnt_q != '1);
    end
  end
  always_ff @(posedge v_clk0) begin
    if (v_rst0) begin
      state_q <= IDLE;
      sel_q   <= '0;
      mask_q  <= '0;
      value_q <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
      elig_q  <= 1'b0;
      s1_q    <= '0;
      pd_q    <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      mask_q  <= mask_d;
      value_q <= value_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      trig_q  <= trig_d;
      elig_q  <= elig_d;
      s1_q    <= src[sel_q];
      pd_q    <= s1_q;
    end
  end
  assign v_probe_data = pd_q;
  assign v_probe_en   = state_q == CAPTURE;
  assign v_trig_out   = trig_q;
  assign v_state      = state_q;
  assign v_done       = state_q == DONE;
  assign v_sample_cnt = cnt_q;
endmodule
